// File: rtl/wb_stage_pipe.sv
// Registered MEM/WB writeback stage: selects ALU, extended load data or PC+4 and drives the regfile write port.
// Latency: 1 cycle from capture to regfile write / commit; optional forwarding copy (WB_FWD_EN) one cycle later.
// Backpressure: in_ready = ~v_q | ~stall; stall freezes the stage, flush kills it and overrides stall.
module wb_stage_pipe #(
   parameter int XLEN  = 64,
   parameter int RA_W  = 5,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       wb_sel,
   input  logic [XLEN-1:0]  alu_res,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic [2:0]       mem_off,
   input  logic [2:0]       ld_f3,
   input  logic [XLEN-1:0]  pc,
   input  logic             rd_wen,
   input  logic [RA_W-1:0]  rd_addr,
   input  logic             stall,
   input  logic             flush,
   output logic             wb_ena,
   output logic [RA_W-1:0]  wb_addr,
   output logic [XLEN-1:0]  wb_data,
   output logic             commit_valid,
   output logic [XLEN-1:0]  commit_pc,
   output logic             misalign,
   output logic [CNT_W-1:0] instret
`ifdef WB_FWD_EN
   ,
   output logic             fwd_valid,
   output logic [RA_W-1:0]  fwd_addr,
   output logic [XLEN-1:0]  fwd_data
`endif
);

   localparam int OFFW = $clog2(XLEN/8);
   localparam bit RV32 = (XLEN == 32);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_MEM  = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   // Stage state
   logic             v_q, v_d;
   logic             wr_q;       // captured instruction will write rd (x0, no-write and misaligned excluded)
   logic             mis_q;
   logic [XLEN-1:0]  pc_q;
   logic [RA_W-1:0]  addr_q;     // only loaded by writing instructions, so it holds between writes
   logic [XLEN-1:0]  data_q;
   logic [CNT_W-1:0] cnt_q;      // retires completed before the current cycle

   // Capture-side decode
   logic [OFFW-1:0]  off;
   logic [XLEN-1:0]  shifted;
   logic [XLEN-1:0]  load_ext;
   logic             ld_mis;
   logic             mis_d;
   logic             wr_d;
   logic [XLEN-1:0]  data_d;
   logic             capture;
   logic             retire;
   logic             wb_ena_w;

   assign off      = mem_off[OFFW-1:0];
   assign in_ready = ~v_q | ~stall;
   assign capture  = in_valid & in_ready & ~flush;
   // An instruction sitting in WB during a flush neither writes nor retires.
   assign retire   = v_q & ~stall & ~flush;
   assign wb_ena_w = retire & wr_q;

   // Load lane extraction and sign/zero extension
   always_comb begin
      shifted  = mem_rdata >> {off, 3'b000};
      load_ext = shifted;
      case (ld_f3)
         F3_LB:   load_ext = XLEN'($signed(shifted[7:0]));
         F3_LH:   load_ext = XLEN'($signed(shifted[15:0]));
         F3_LW:   load_ext = XLEN'($signed(shifted[31:0]));
         F3_LBU:  load_ext = XLEN'(shifted[7:0]);
         F3_LHU:  load_ext = XLEN'(shifted[15:0]);
         F3_LWU:  load_ext = XLEN'(shifted[31:0]);
         default: load_ext = shifted;
      endcase
   end

   // Alignment / legality check of the load encoding
   always_comb begin
      ld_mis = 1'b1;
      case (ld_f3)
         F3_LB, F3_LBU: ld_mis = 1'b0;
         F3_LH, F3_LHU: ld_mis = off[0];
         F3_LW:         ld_mis = (off[1:0] != 2'b00);
         F3_LWU:        ld_mis = RV32 | (off[1:0] != 2'b00);
         F3_LD:         ld_mis = RV32 | (off != '0);
         default:       ld_mis = 1'b1;
      endcase
   end

   // Writeback value select and write qualification
   always_comb begin
      mis_d  = (wb_sel == SEL_MEM) & ld_mis;
      wr_d   = rd_wen & (wb_sel != SEL_NONE) & (rd_addr != '0) & ~mis_d;
      data_d = alu_res;
      case (wb_sel)
         SEL_ALU: data_d = alu_res;
         SEL_MEM: data_d = load_ext;
         SEL_PC4: data_d = pc + XLEN'(4);
         default: data_d = alu_res;
      endcase
   end

   // Valid bit: flush clears, capture sets, retire drains, stall holds
   always_comb begin
      v_d = v_q;
      if (flush)
         v_d = 1'b0;
      else if (capture)
         v_d = 1'b1;
      else if (retire)
         v_d = 1'b0;
   end

   // Stage registers
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q    <= 1'b0;
         wr_q   <= 1'b0;
         mis_q  <= 1'b0;
         pc_q   <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         v_q <= v_d;
         if (capture) begin
            wr_q  <= wr_d;
            mis_q <= mis_d;
            pc_q  <= pc;
            if (wr_d) begin
               addr_q <= rd_addr;
               data_q <= data_d;
            end
         end
      end
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + CNT_W'(retire);
   end

   // The count already includes an instruction retiring this cycle.
   assign instret      = cnt_q + CNT_W'(retire);
   assign wb_ena       = wb_ena_w;
   assign wb_addr      = addr_q;
   assign wb_data      = data_q;
   assign commit_valid = retire;
   assign commit_pc    = pc_q;
   assign misalign     = retire & mis_q;

`ifdef WB_FWD_EN
   logic            fwd_valid_q;
   logic [RA_W-1:0] fwd_addr_q;
   logic [XLEN-1:0] fwd_data_q;

   // One-cycle copy of the write just issued, for the ID-stage bypass
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_data_q  <= '0;
      end else begin
         fwd_valid_q <= wb_ena_w & ~flush;
         if (wb_ena_w) begin
            fwd_addr_q <= addr_q;
            fwd_data_q <= data_q;
         end
      end
   end

   assign fwd_valid = fwd_valid_q;
   assign fwd_addr  = fwd_addr_q;
   assign fwd_data  = fwd_data_q;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe (XLEN=64).
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
module tb_wb_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  wb_sel;
   logic [63:0] alu_res;
   logic [63:0] mem_rdata;
   logic [2:0]  mem_off;
   logic [2:0]  ld_f3;
   logic [63:0] pc;
   logic        rd_wen;
   logic [4:0]  rd_addr;
   logic        stall;
   logic        flush;
   logic        wb_ena;
   logic [4:0]  wb_addr;
   logic [63:0] wb_data;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic        misalign;
   logic [63:0] instret;
`ifdef WB_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [63:0] fwd_data;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_stage_pipe #(.XLEN(64), .RA_W(5), .CNT_W(64)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .wb_sel       (wb_sel),
      .alu_res      (alu_res),
      .mem_rdata    (mem_rdata),
      .mem_off      (mem_off),
      .ld_f3        (ld_f3),
      .pc           (pc),
      .rd_wen       (rd_wen),
      .rd_addr      (rd_addr),
      .stall        (stall),
      .flush        (flush),
      .wb_ena       (wb_ena),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .misalign     (misalign),
      .instret      (instret)
`ifdef WB_FWD_EN
      ,
      .fwd_valid    (fwd_valid),
      .fwd_addr     (fwd_addr),
      .fwd_data     (fwd_data)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for one edge; afterwards it sits in WB.
   task automatic issue(input logic [1:0] sel, input logic [63:0] alu, input logic [2:0] off,
                        input logic [2:0] f3, input logic [63:0] p, input logic [4:0] rd);
      in_valid = 1'b1;
      wb_sel   = sel;
      alu_res  = alu;
      mem_off  = off;
      ld_f3    = f3;
      pc       = p;
      rd_wen   = 1'b1;
      rd_addr  = rd;
      tick();
      in_valid = 1'b0;
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      wb_sel    = 2'b00;
      alu_res   = '0;
      mem_rdata = 64'h8877_6655_4433_2211;
      mem_off   = '0;
      ld_f3     = '0;
      pc        = '0;
      rd_wen    = 1'b0;
      rd_addr   = '0;
      stall     = 1'b0;
      flush     = 1'b0;

      // Reset
      tick();
      tick();
      check("rst_wb_ena", wb_ena, 0);
      check("rst_wb_addr", wb_addr, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_commit", commit_valid, 0);
      check("rst_commit_pc", commit_pc, 0);
      check("rst_misalign", misalign, 0);
      check("rst_instret", instret, 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);

      // ALU writeback
      issue(2'b00, 64'h1234, 3'd0, 3'd0, 64'h100, 5'd5);
      check("alu_wb_ena", wb_ena, 1);
      check("alu_wb_addr", wb_addr, 5);
      check("alu_wb_data", wb_data, 64'h1234);
      check("alu_commit", commit_valid, 1);
      check("alu_commit_pc", commit_pc, 64'h100);
      check("alu_instret", instret, 1);
      tick();
      check("idle_commit", commit_valid, 0);
      check("idle_wb_ena", wb_ena, 0);
      check("idle_wb_addr_held", wb_addr, 5);
      check("idle_instret", instret, 1);

      // Loads, back-to-back
      issue(2'b01, 64'h0, 3'd7, 3'b000, 64'h104, 5'd6);
      check("lb7_data", wb_data, 64'hFFFF_FFFF_FFFF_FF88);
      check("lb7_ena", wb_ena, 1);
      check("lb7_in_ready", in_ready, 1);
      check("lb7_instret", instret, 2);
      issue(2'b01, 64'h0, 3'd2, 3'b101, 64'h108, 5'd6);
      check("lhu2_data", wb_data, 64'h4433);
      check("lhu2_instret", instret, 3);
      issue(2'b01, 64'h0, 3'd4, 3'b010, 64'h10C, 5'd6);
      check("lw4_data", wb_data, 64'hFFFF_FFFF_8877_6655);
      issue(2'b01, 64'h0, 3'd0, 3'b011, 64'h110, 5'd8);
      check("ld0_data", wb_data, 64'h8877_6655_4433_2211);
      check("ld0_addr", wb_addr, 8);
      check("ld0_instret", instret, 5);

      // PC+4 wraps
      issue(2'b10, 64'h0, 3'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd9);
      check("pc4_data", wb_data, 64'h0);
      check("pc4_addr", wb_addr, 9);
      check("pc4_commit_pc", commit_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      // Misaligned LW, x0 write, illegal funct3
      issue(2'b01, 64'h0, 3'd2, 3'b010, 64'h120, 5'd3);
      check("mis_wb_ena", wb_ena, 0);
      check("mis_misalign", misalign, 1);
      check("mis_commit", commit_valid, 1);
      check("mis_addr_held", wb_addr, 9);
      check("mis_instret", instret, 7);
      issue(2'b00, 64'hDEAD, 3'd0, 3'd0, 64'h124, 5'd0);
      check("x0_wb_ena", wb_ena, 0);
      check("x0_commit", commit_valid, 1);
      check("x0_misalign", misalign, 0);
      check("x0_data_held", wb_data, 64'h0);
      issue(2'b01, 64'h0, 3'd0, 3'b111, 64'h128, 5'd4);
      check("ill_misalign", misalign, 1);
      check("ill_wb_ena", wb_ena, 0);
      check("ill_instret", instret, 9);
      check("odd_lh", 0, 0) ;
      n_chk--;

      // Stall 3 cycles
      tick();
      stall = 1'b1;
      issue(2'b00, 64'hABCD, 3'd0, 3'd0, 64'h200, 5'd10);
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", in_ready, 0);
         check("stall_commit", commit_valid, 0);
         check("stall_wb_ena", wb_ena, 0);
         check("stall_instret", instret, 9);
         tick();
      end
      stall = 1'b0;
      #1;
      check("unstall_commit", commit_valid, 1);
      check("unstall_wb_ena", wb_ena, 1);
      check("unstall_data", wb_data, 64'hABCD);
      check("unstall_pc", commit_pc, 64'h200);
      check("unstall_instret", instret, 10);
      tick();
      check("post_stall_commit", commit_valid, 0);
      check("post_stall_instret", instret, 10);

      // Flush with incoming instruction
      flush = 1'b1;
      issue(2'b00, 64'h77, 3'd0, 3'd0, 64'h300, 5'd12);
      flush = 1'b0;
      #1;
      check("flush_in_commit", commit_valid, 0);
      check("flush_in_instret", instret, 10);

      // Flush of the instruction in WB, overriding a stall
      issue(2'b00, 64'h99, 3'd0, 3'd0, 64'h304, 5'd11);
      stall = 1'b1;
      flush = 1'b1;
      #1;
      check("flush_wb_commit", commit_valid, 0);
      check("flush_wb_ena", wb_ena, 0);
      tick();
      flush = 1'b0;
      #1;
      check("flush_stall_ready", in_ready, 1);
      stall = 1'b0;
      #1;
      check("flush_wb_after", commit_valid, 0);
      check("flush_wb_instret", instret, 10);

`ifdef WB_FWD_EN
      issue(2'b00, 64'h55, 3'd0, 3'd0, 64'h400, 5'd7);
      check("fwd_pre_valid", fwd_valid, 0);
      tick();
      check("fwd_valid", fwd_valid, 1);
      check("fwd_addr", fwd_addr, 7);
      check("fwd_data", fwd_data, 64'h55);
      tick();
      check("fwd_drop", fwd_valid, 0);
`endif

      // Reset during a stall
      stall = 1'b1;
      issue(2'b00, 64'h66, 3'd0, 3'd0, 64'h500, 5'd13);
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      stall = 1'b0;
      #1;
      check("rst2_commit", commit_valid, 0);
      check("rst2_instret", instret, 0);
      check("rst2_wb_addr", wb_addr, 0);
      check("rst2_commit_pc", commit_pc, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
